uart_rx_deserializer: RTL and testbench

//  Receive side of the team UART. Detects a start bit on the serial line, samples each bit at mid-period

---
 rtl/uart_rx_deserializer_if.sv | 29 ++
 rtl/uart_rx_deserializer.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_deserializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_rx_deserializer_if                                           |
// | Brief  : Serial line, baud code and holding-register handshake for UART RX |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
interface uart_rx_deserializer_if #(
  parameter int DATA_BITS = 8
);
  logic [3:0]           baud_select;
  logic                 rx;
  logic                 rx_read;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 parity_err;
  logic                 framing_err;
  logic                 overrun_err;

  modport master (
    output baud_select, rx, rx_read,
    input  rx_data, rx_valid, parity_err, framing_err, overrun_err
  );

  modport slave (
    input  baud_select, rx, rx_read,
    output rx_data, rx_valid, parity_err, framing_err, overrun_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_deserializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : uart_rx_deserializer                                              |
// | Brief  : UART receiver, mid-bit sampling, one-entry holding register       |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module uart_rx_deserializer #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  wire logic             clk,
  input  wire logic             rstb,
  uart_rx_deserializer_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic [2:0] c_LAST_IDX = 3'(DATA_BITS - 1);
  localparam logic       c_ODD      = (PARITY_ODD != 0);
  localparam state_t     c_AFTER_DATA = (PARITY_EN != 0) ? S_PARITY : S_STOP;

  logic [1:0]           r_sync;
  logic                 w_rx_s;
  logic [17:0]          w_div;
  logic [17:0]          r_div;
  logic [17:0]          r_cnt;
  logic                 w_tick;
  logic                 w_half;
  logic                 w_done;
  state_t               r_state;
  logic [2:0]           r_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_perr;
  logic [DATA_BITS-1:0] r_data;
  logic                 r_valid;
  logic                 r_par_err;
  logic                 r_frm_err;
  logic                 r_ovr_err;

  // Synchronizer resets to the idle (high) line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_sync <= 2'b11;
    end else begin
      r_sync <= {r_sync[0], bus.rx};
    end
  end

  assign w_rx_s = r_sync[1];

  always_comb begin
    w_div = 18'd5208;
    case (bus.baud_select)
      4'd0:    w_div = 18'd166667;
      4'd1:    w_div = 18'd41667;
      4'd2:    w_div = 18'd20833;
      4'd3:    w_div = 18'd10417;
      4'd4:    w_div = 18'd5208;
      4'd5:    w_div = 18'd2604;
      4'd6:    w_div = 18'd1302;
      4'd7:    w_div = 18'd868;
      4'd8:    w_div = 18'd434;
      4'd9:    w_div = 18'd217;
      4'd10:   w_div = 18'd109;
      4'd11:   w_div = 18'd54;
      default: w_div = 18'd5208;
    endcase
  end

  assign w_tick = (r_cnt == r_div);
  assign w_half = (r_cnt == (r_div >> 1));
  assign w_done = (r_state == S_STOP) && w_tick;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      r_state   <= S_IDLE;
      r_cnt     <= 18'd0;
      r_div     <= 18'd0;
      r_idx     <= 3'd0;
      r_shift   <= '0;
      r_perr    <= 1'b0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_par_err <= 1'b0;
      r_frm_err <= 1'b0;
      r_ovr_err <= 1'b0;
    end else begin
      r_cnt <= r_cnt + 18'd1;
      case (r_state)
        S_IDLE: begin
          r_cnt <= 18'd0;
          if (!w_rx_s) begin
            r_state <= S_START;
            r_div   <= w_div;
            r_idx   <= 3'd0;
            r_perr  <= 1'b0;
          end
        end
        S_START: begin
          if (w_half) begin
            r_cnt   <= 18'd0;
            r_state <= w_rx_s ? S_IDLE : S_DATA;
          end
        end
        S_DATA: begin
          if (w_tick) begin
            r_cnt          <= 18'd0;
            r_shift[r_idx] <= w_rx_s;
            r_idx          <= r_idx + 3'd1;
            if (r_idx == c_LAST_IDX) begin
              r_state <= c_AFTER_DATA;
            end
          end
        end
        S_PARITY: begin
          if (w_tick) begin
            r_cnt   <= 18'd0;
            r_perr  <= ((^r_shift) ^ w_rx_s) != c_ODD;
            r_state <= S_STOP;
          end
        end
        S_STOP: begin
          // Returning to IDLE on the sample point lets a back-to-back start bit be caught.
          if (w_tick) begin
            r_cnt   <= 18'd0;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_cnt   <= 18'd0;
          r_state <= S_IDLE;
        end
      endcase

      // A read in the completion cycle frees the register before the new frame lands.
      if (w_done) begin
        if (!r_valid || bus.rx_read) begin
          r_data    <= r_shift;
          r_par_err <= r_perr;
          r_frm_err <= ~w_rx_s;
          r_ovr_err <= 1'b0;
          r_valid   <= 1'b1;
        end else begin
          r_ovr_err <= 1'b1;
        end
      end else if (bus.rx_read && r_valid) begin
        r_valid   <= 1'b0;
        r_par_err <= 1'b0;
        r_frm_err <= 1'b0;
        r_ovr_err <= 1'b0;
      end
    end
  end

  assign bus.rx_data     = r_data;
  assign bus.rx_valid    = r_valid;
  assign bus.parity_err  = r_par_err;
  assign bus.framing_err = r_frm_err;
  assign bus.overrun_err = r_ovr_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module : tb_uart_rx_deserializer                                           |
// | Brief  : Directed frames into an 8N1 and an 8E1 receiver                   |
// | Rev    : 1.0                                                               |
// +----------------------------------------------------------------------------+
module tb_uart_rx_deserializer;

  logic clk;
  logic rstb;
  int   checks;
  int   failures;

  uart_rx_deserializer_if #(.DATA_BITS(8)) ifn ();
  uart_rx_deserializer_if #(.DATA_BITS(8)) ifp ();

  uart_rx_deserializer #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) u_dut_n (
    .clk  (clk),
    .rstb (rstb),
    .bus  (ifn)
  );

  uart_rx_deserializer #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) u_dut_p (
    .clk  (clk),
    .rstb (rstb),
    .bus  (ifp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #950000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic set_rx(input bit sel, input logic b);
    if (sel) ifp.rx = b;
    else     ifn.rx = b;
  endtask

  // Caller is on a falling edge; returns on the falling edge that ends the stop bit.
  task automatic send_frame(input bit sel, input logic [7:0] d, input logic par_en,
                            input logic par_bit, input logic stop_bit, input int period);
    set_rx(sel, 1'b0);
    repeat (period) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, d[i]);
      repeat (period) @(negedge clk);
    end
    if (par_en) begin
      set_rx(sel, par_bit);
      repeat (period) @(negedge clk);
    end
    set_rx(sel, stop_bit);
    repeat (period) @(negedge clk);
    set_rx(sel, 1'b1);
  endtask

  task automatic read_pulse(input bit sel);
    if (sel) ifp.rx_read = 1'b1;
    else     ifn.rx_read = 1'b1;
    @(negedge clk);
    ifp.rx_read = 1'b0;
    ifn.rx_read = 1'b0;
  endtask

  task automatic test_reset();
    rstb = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ifn.rx_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%b exp=0", ifn.rx_valid); end
    checks++; if (ifn.rx_data !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", ifn.rx_data); end
    checks++; if ({ifn.parity_err, ifn.framing_err, ifn.overrun_err} !== 3'b000) begin
      failures++; $display("FAIL rst_flags got=%b exp=000", {ifn.parity_err, ifn.framing_err, ifn.overrun_err}); end
    checks++; if (ifp.rx_valid !== 1'b0) begin failures++; $display("FAIL rst_valid_p got=%b exp=0", ifp.rx_valid); end
    rstb = 1'b1;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_basic();
    int cyc;
    ifn.baud_select = 4'd4;
    repeat (5) @(negedge clk);
    cyc = 0;
    fork
      send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1, 5209);
      begin
        while (ifn.rx_valid !== 1'b1 && cyc < 60000) begin
          @(negedge clk);
          cyc++;
        end
      end
    join
    checks++; if (ifn.rx_valid !== 1'b1) begin failures++; $display("FAIL t1_valid got=%b exp=1", ifn.rx_valid); end
    checks++; if (ifn.rx_data !== 8'hA5) begin failures++; $display("FAIL t1_data got=%h exp=a5", ifn.rx_data); end
    checks++; if ({ifn.parity_err, ifn.framing_err, ifn.overrun_err} !== 3'b000) begin
      failures++; $display("FAIL t1_flags got=%b exp=000", {ifn.parity_err, ifn.framing_err, ifn.overrun_err}); end
    checks++; if (cyc < 49480 || cyc > 49500) begin failures++; $display("FAIL t1_latency got=%0d exp=49489", cyc); end
    read_pulse(1'b0);
    checks++; if (ifn.rx_valid !== 1'b0) begin failures++; $display("FAIL t1_read got=%b exp=0", ifn.rx_valid); end
  endtask

  task automatic test_glitch();
    ifn.baud_select = 4'd4;
    ifn.rx = 1'b0;
    repeat (1000) @(negedge clk);
    ifn.rx = 1'b1;
    repeat (6000) @(negedge clk);
    checks++; if (ifn.rx_valid !== 1'b0) begin failures++; $display("FAIL t2_glitch got=%b exp=0", ifn.rx_valid); end
    ifn.baud_select = 4'd11;
    @(negedge clk);
    send_frame(1'b0, 8'hC3, 1'b0, 1'b0, 1'b1, 55);
    repeat (3) @(negedge clk);
    checks++; if (ifn.rx_data !== 8'hC3 || ifn.rx_valid !== 1'b1) begin
      failures++; $display("FAIL t2_after got=%h/%b exp=c3/1", ifn.rx_data, ifn.rx_valid); end
    read_pulse(1'b0);
  endtask

  task automatic test_framing();
    ifn.baud_select = 4'd11;
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 55);
    repeat (10) @(negedge clk);
    checks++; if (ifn.rx_valid !== 1'b1) begin failures++; $display("FAIL t3_valid got=%b exp=1", ifn.rx_valid); end
    checks++; if (ifn.rx_data !== 8'h3C) begin failures++; $display("FAIL t3_data got=%h exp=3c", ifn.rx_data); end
    checks++; if (ifn.framing_err !== 1'b1) begin failures++; $display("FAIL t3_ferr got=%b exp=1", ifn.framing_err); end
    checks++; if (ifn.parity_err !== 1'b0) begin failures++; $display("FAIL t3_perr got=%b exp=0", ifn.parity_err); end
    read_pulse(1'b0);
    checks++; if ({ifn.rx_valid, ifn.framing_err, ifn.parity_err, ifn.overrun_err} !== 4'b0000) begin
      failures++; $display("FAIL t3_clear got=%b exp=0000", {ifn.rx_valid, ifn.framing_err, ifn.parity_err, ifn.overrun_err}); end
  endtask

  task automatic test_parity();
    ifp.baud_select = 4'd11;
    @(negedge clk);
    send_frame(1'b1, 8'h01, 1'b1, 1'b0, 1'b1, 55);
    repeat (3) @(negedge clk);
    checks++; if (ifp.parity_err !== 1'b1 || ifp.rx_valid !== 1'b1) begin
      failures++; $display("FAIL t4_bad_par got=%b/%b exp=1/1", ifp.parity_err, ifp.rx_valid); end
    checks++; if (ifp.rx_data !== 8'h01 || ifp.framing_err !== 1'b0) begin
      failures++; $display("FAIL t4_data got=%h/%b exp=01/0", ifp.rx_data, ifp.framing_err); end
    read_pulse(1'b1);
    send_frame(1'b1, 8'h01, 1'b1, 1'b1, 1'b1, 55);
    repeat (3) @(negedge clk);
    checks++; if (ifp.parity_err !== 1'b0 || ifp.rx_valid !== 1'b1) begin
      failures++; $display("FAIL t4_good_par got=%b/%b exp=0/1", ifp.parity_err, ifp.rx_valid); end
    read_pulse(1'b1);
  endtask

  task automatic test_back_to_back();
    ifn.baud_select = 4'd11;
    @(negedge clk);
    send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1, 55);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1, 55);
    repeat (3) @(negedge clk);
    checks++; if (ifn.rx_data !== 8'h11) begin failures++; $display("FAIL t5_held got=%h exp=11", ifn.rx_data); end
    checks++; if (ifn.overrun_err !== 1'b1 || ifn.rx_valid !== 1'b1) begin
      failures++; $display("FAIL t5_ovr got=%b/%b exp=1/1", ifn.overrun_err, ifn.rx_valid); end
    fork
      send_frame(1'b0, 8'h33, 1'b0, 1'b0, 1'b1, 55);
      begin
        repeat (200) @(negedge clk);
        read_pulse(1'b0);
        checks++; if (ifn.rx_valid !== 1'b0 || ifn.overrun_err !== 1'b0) begin
          failures++; $display("FAIL t5_mid_read got=%b/%b exp=0/0", ifn.rx_valid, ifn.overrun_err); end
      end
    join
    repeat (3) @(negedge clk);
    checks++; if (ifn.rx_data !== 8'h33 || ifn.rx_valid !== 1'b1 || ifn.overrun_err !== 1'b0) begin
      failures++; $display("FAIL t5_frame3 got=%h/%b/%b exp=33/1/0", ifn.rx_data, ifn.rx_valid, ifn.overrun_err); end
    // Read lands exactly on the stop-bit sample cycle of the next frame.
    fork
      send_frame(1'b0, 8'h44, 1'b0, 1'b0, 1'b1, 55);
      begin
        repeat (525) @(negedge clk);
        read_pulse(1'b0);
      end
    join
    repeat (3) @(negedge clk);
    checks++; if (ifn.rx_data !== 8'h44 || ifn.rx_valid !== 1'b1 || ifn.overrun_err !== 1'b0) begin
      failures++; $display("FAIL t5_read_collide got=%h/%b/%b exp=44/1/0", ifn.rx_data, ifn.rx_valid, ifn.overrun_err); end
    read_pulse(1'b0);
  endtask

  task automatic test_abort_and_rate();
    ifn.baud_select = 4'd11;
    @(negedge clk);
    ifn.rx = 1'b0;
    repeat (165) @(negedge clk);
    rstb = 1'b0;
    ifn.rx = 1'b1;
    repeat (3) @(negedge clk);
    rstb = 1'b1;
    repeat (1000) @(negedge clk);
    checks++; if (ifn.rx_valid !== 1'b0 || ifn.rx_data !== 8'h00) begin
      failures++; $display("FAIL t6_abort got=%b/%h exp=0/00", ifn.rx_valid, ifn.rx_data); end
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1, 55);
    repeat (3) @(negedge clk);
    checks++; if (ifn.rx_data !== 8'h5A || ifn.rx_valid !== 1'b1) begin
      failures++; $display("FAIL t6_after_rst got=%h/%b exp=5a/1", ifn.rx_data, ifn.rx_valid); end
    read_pulse(1'b0);
    fork
      send_frame(1'b0, 8'h96, 1'b0, 1'b0, 1'b1, 55);
      begin
        repeat (100) @(negedge clk);
        ifn.baud_select = 4'd4;
      end
    join
    repeat (3) @(negedge clk);
    checks++; if (ifn.rx_data !== 8'h96 || ifn.rx_valid !== 1'b1 || ifn.framing_err !== 1'b0) begin
      failures++; $display("FAIL t6_baud_change got=%h/%b/%b exp=96/1/0", ifn.rx_data, ifn.rx_valid, ifn.framing_err); end
    ifn.baud_select = 4'd11;
    read_pulse(1'b0);
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    rstb            = 1'b0;
    ifn.rx          = 1'b1;
    ifn.rx_read     = 1'b0;
    ifn.baud_select = 4'd4;
    ifp.rx          = 1'b1;
    ifp.rx_read     = 1'b0;
    ifp.baud_select = 4'd11;
    @(negedge clk);
    test_reset();
    test_basic();
    test_glitch();
    test_framing();
    test_parity();
    test_back_to_back();
    test_abort_and_rate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
